// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and default-width queue entry for the fetch stage
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  localparam int unsigned FETCH_XLEN_DEF = 32;
  localparam int unsigned FETCH_ADDR_DEF = 32;

  // Queue entry at the default widths; pc sits above data when packed.
  typedef struct packed {
    logic [FETCH_ADDR_DEF-1:0] pc;
    logic [FETCH_XLEN_DEF-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush, occupancy count and registered head
module fetch_fifo #(
  parameter int unsigned QDEPTH = 4,
  parameter int unsigned WIDTH  = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [$clog2(QDEPTH):0]    count_o,
  output logic [WIDTH-1:0]           head_o
);

  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(QDEPTH);

  logic [WIDTH-1:0] mem_q [QDEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign push_ok = push_i & (count_q != FULL_C);
  assign pop_ok  = pop_i & (count_q != '0);

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Flush wins over push/pop so a redirect never keeps stale entries.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !rst_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - sequential instruction fetch with prefetch queue and redirect handling
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned READ_ADDR_SIZE = 32,
  parameter int unsigned QDEPTH         = 4,
  parameter int unsigned INSTR_BYTES    = 4,
  parameter logic [READ_ADDR_SIZE-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      startSig,
  input  logic                      interrupt_start,
  input  logic                      branch_redirect,
  input  logic [READ_ADDR_SIZE-1:0] redirect_pc,
  input  logic                      beforePipReadyToSend,
  output logic                      mem_readEn,
  output logic [READ_ADDR_SIZE-1:0] mem_read_addr,
  input  logic [XLEN-1:0]           mem_read_data,
  input  logic                      readFin,
  input  logic                      nextPipReadyToRcv,
  output logic                      curPipReadyToSend,
  output logic                      curPipReadyToRcv,
  output logic [XLEN-1:0]           fetch_data,
  output logic [READ_ADDR_SIZE-1:0] fetch_cur_pc,
  output logic [READ_ADDR_SIZE-1:0] fetch_nxt_pc
);

  localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;
  localparam logic [CNT_W-1:0] QDEPTH_C = CNT_W'(QDEPTH);
  localparam logic [READ_ADDR_SIZE-1:0] STEP_C = READ_ADDR_SIZE'(INSTR_BYTES);

  typedef struct packed {
    logic [READ_ADDR_SIZE-1:0] pc;
    logic [XLEN-1:0]           data;
  } entry_t;

  fetch_state_e              state_q;
  logic [READ_ADDR_SIZE-1:0] fetch_pc_q;
  logic                      drop_q;
  logic                      mem_read_en_q;

  logic                      redirect;
  logic                      push;
  logic                      pop;
  logic                      head_valid;
  logic                      issue;
  fetch_state_e              go_state;
  logic [CNT_W-1:0]          count;
  logic [CNT_W-1:0]          count_next;
  entry_t                    push_entry;
  entry_t                    head;

  assign redirect   = startSig | interrupt_start | branch_redirect;
  assign push       = (state_q == ST_REQ) & readFin & ~redirect;
  assign head_valid = (count != '0) & ~redirect;
  assign pop        = head_valid & nextPipReadyToRcv;

  // Occupancy after this edge, used to reserve a slot before issuing.
  always_comb begin
    count_next = count;
    if (redirect) begin
      count_next = '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_next = count + CNT_W'(1);
        2'b01:   count_next = count - CNT_W'(1);
        default: count_next = count;
      endcase
    end
  end

  assign issue    = beforePipReadyToSend & (count_next < QDEPTH_C);
  assign go_state = issue ? ST_REQ : ST_HOLD;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      fetch_pc_q    <= RESET_PC;
      drop_q        <= 1'b0;
      mem_read_en_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (redirect) begin
            fetch_pc_q    <= redirect_pc;
            state_q       <= go_state;
            mem_read_en_q <= issue;
          end
        end
        ST_REQ: begin
          if (redirect) begin
            fetch_pc_q <= redirect_pc;
            if (readFin) begin
              state_q       <= go_state;
              mem_read_en_q <= issue;
            end else begin
              // Read still in flight: wait for its completion and discard it.
              state_q       <= ST_DRAIN;
              drop_q        <= 1'b1;
              mem_read_en_q <= 1'b0;
            end
          end else if (readFin) begin
            fetch_pc_q    <= fetch_pc_q + STEP_C;
            state_q       <= go_state;
            mem_read_en_q <= issue;
          end
        end
        ST_HOLD: begin
          if (redirect) fetch_pc_q <= redirect_pc;
          state_q       <= go_state;
          mem_read_en_q <= issue;
        end
        ST_DRAIN: begin
          if (redirect) fetch_pc_q <= redirect_pc;
          if (readFin && drop_q) begin
            drop_q        <= 1'b0;
            state_q       <= go_state;
            mem_read_en_q <= issue;
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          mem_read_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign push_entry = '{pc: fetch_pc_q, data: mem_read_data};

  fetch_fifo #(
    .QDEPTH (QDEPTH),
    .WIDTH  (READ_ADDR_SIZE + XLEN)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (redirect),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .count_o     (count),
    .head_o      (head)
  );

  assign mem_readEn        = mem_read_en_q;
  assign mem_read_addr     = fetch_pc_q;
  assign curPipReadyToSend = head_valid;
  assign curPipReadyToRcv  = (state_q != ST_IDLE) & ~redirect;

  // Head fields read as zero while the queue is empty, matching the reset view.
  assign fetch_data   = (count != '0) ? head.data : '0;
  assign fetch_cur_pc = (count != '0) ? head.pc : '0;
  assign fetch_nxt_pc = (count != '0) ? (head.pc + STEP_C) : '0;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb/tb_fetch_prefetch_queue.sv - scoreboard bench for fetch_prefetch_queue
module tb_fetch_prefetch_queue;
  import fetch_pkg::*;

  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        startSig = 1'b0, interrupt_start = 1'b0, branch_redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        beforePipReadyToSend = 1'b0;
  logic        mem_readEn;
  logic [31:0] mem_read_addr;
  logic [31:0] mem_read_data = '0;
  logic        readFin = 1'b0;
  logic        nextPipReadyToRcv = 1'b0;
  logic        curPipReadyToSend, curPipReadyToRcv;
  logic [31:0] fetch_data, fetch_cur_pc, fetch_nxt_pc;

  always #5 clk = ~clk;

  fetch_prefetch_queue #(
    .XLEN(32), .READ_ADDR_SIZE(32), .QDEPTH(QD), .INSTR_BYTES(4), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .startSig(startSig), .interrupt_start(interrupt_start),
    .branch_redirect(branch_redirect), .redirect_pc(redirect_pc),
    .beforePipReadyToSend(beforePipReadyToSend), .mem_readEn(mem_readEn),
    .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data), .readFin(readFin),
    .nextPipReadyToRcv(nextPipReadyToRcv), .curPipReadyToSend(curPipReadyToSend),
    .curPipReadyToRcv(curPipReadyToRcv), .fetch_data(fetch_data),
    .fetch_cur_pc(fetch_cur_pc), .fetch_nxt_pc(fetch_nxt_pc)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  fetch_entry_t sb[$];

  logic        k_rst = 1'b1, k_start = 1'b0, k_ready = 1'b0, k_before = 1'b0;
  logic [31:0] k_pc = '0;
  int          lat = 2;
  logic        irq_on_fin = 1'b0;
  logic [31:0] irq_pc = '0;
  logic        br_on_req = 1'b0;
  logic [31:0] br_addr = '0, br_pc = '0;

  logic        pend = 1'b0, dirty = 1'b0, fired = 1'b0, saw_zero = 1'b0;
  logic [31:0] pend_addr = '0, last_req = '0, exp_pc = '0;
  int          cnt = 0, req_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  // One clock of stimulus, memory response and scoreboard update.
  task automatic cycle();
    logic redir;
    @(posedge clk);
    #1;
    if (pend && dirty) check("drain_no_req", {63'd0, mem_readEn}, 64'd0);
    rst = k_rst;
    startSig = k_start;
    interrupt_start = 1'b0;
    branch_redirect = 1'b0;
    redirect_pc = k_pc;
    nextPipReadyToRcv = k_ready;
    beforePipReadyToSend = k_before;
    readFin = 1'b0;
    mem_read_data = '0;
    fired = 1'b0;
    k_start = 1'b0;
    if (pend) begin
      if (mem_readEn) check("addr_stable", {32'd0, mem_read_addr}, {32'd0, pend_addr});
      cnt--;
      if (cnt == 0) begin
        readFin = 1'b1;
        mem_read_data = mem_word(pend_addr);
        fired = 1'b1;
        if (irq_on_fin) begin
          interrupt_start = 1'b1;
          redirect_pc = irq_pc;
          nextPipReadyToRcv = 1'b1;
          irq_on_fin = 1'b0;
        end
      end
    end else if (mem_readEn === 1'b1) begin
      pend = 1'b1;
      pend_addr = mem_read_addr;
      cnt = lat;
      dirty = 1'b0;
      req_cnt++;
      last_req = mem_read_addr;
      if (mem_read_addr == 32'h0) saw_zero = 1'b1;
      check("req_addr", {32'd0, mem_read_addr}, {32'd0, exp_pc});
      if (br_on_req && mem_read_addr == br_addr) begin
        branch_redirect = 1'b1;
        redirect_pc = br_pc;
        br_on_req = 1'b0;
      end
    end
    #1;
    redir = startSig | interrupt_start | branch_redirect;
    if (rst) begin
      sb.delete();
      if (pend && !fired) begin
        dirty = 1'b1;
        cnt = 1;
      end
    end else begin
      check("head_valid", {63'd0, curPipReadyToSend}, {63'd0, (sb.size() != 0) && !redir});
      if (sb.size() != 0 && !redir && nextPipReadyToRcv) begin
        check("head_pc", {32'd0, fetch_cur_pc}, {32'd0, sb[0].pc});
        check("head_data", {32'd0, fetch_data}, {32'd0, sb[0].data});
        check("head_nxt", {32'd0, fetch_nxt_pc}, {32'd0, sb[0].pc + 32'd4});
        void'(sb.pop_front());
      end
      if (redir) begin
        sb.delete();
        exp_pc = redirect_pc;
        if (pend) dirty = 1'b1;
      end
      if (fired && !dirty) begin
        sb.push_back('{pc: pend_addr, data: mem_read_data});
        exp_pc = pend_addr + 32'd4;
        check("depth_ok", {63'd0, sb.size() <= QD}, 64'd1);
      end
    end
    if (fired) pend = 1'b0;
  endtask

  task automatic check_reset_view(input string tag);
    check({tag, "_readEn"}, {63'd0, mem_readEn}, 64'd0);
    check({tag, "_valid"}, {63'd0, curPipReadyToSend}, 64'd0);
    check({tag, "_rcv"}, {63'd0, curPipReadyToRcv}, 64'd0);
    check({tag, "_data"}, {32'd0, fetch_data}, 64'd0);
    check({tag, "_cur"}, {32'd0, fetch_cur_pc}, 64'd0);
    check({tag, "_nxt"}, {32'd0, fetch_nxt_pc}, 64'd0);
  endtask

  initial begin
    int base;
    int base2;
    int vcnt;
    logic found;

    repeat (3) cycle();
    k_rst = 1'b0;
    cycle();
    check_reset_view("reset");

    // 1: start at 0x100, two-cycle memory, decode always ready
    k_before = 1'b1; k_ready = 1'b1; lat = 2;
    k_start = 1'b1; k_pc = 32'h100;
    cycle();
    check("t1_rcv_in_redirect", {63'd0, curPipReadyToRcv}, 64'd0);
    base = req_cnt;
    cycle();
    check("t1_req_next_cycle", {63'd0, mem_readEn}, 64'd1);
    check("t1_first_addr", {32'd0, mem_read_addr}, 64'h100);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      found = fired;
    end
    check("t1_fin_seen", {63'd0, found}, 64'd1);
    cycle();
    check("t1_head_valid", {63'd0, curPipReadyToSend}, 64'd1);
    check("t1_head_pc", {32'd0, fetch_cur_pc}, 64'h100);
    check("t1_head_nxt", {32'd0, fetch_nxt_pc}, 64'h104);
    repeat (8) cycle();
    check("t1_three_reads", {63'd0, (req_cnt - base) >= 3}, 64'd1);

    // 2: decode stalled, queue fills to QDEPTH then one pop frees a slot
    k_ready = 1'b0; k_start = 1'b1; k_pc = 32'h100;
    cycle();
    base = req_cnt;
    repeat (40) cycle();
    check("t2_reads", (req_cnt - base), 64'd4);
    check("t2_last_addr", {32'd0, last_req}, 64'h10C);
    check("t2_full", sb.size(), 64'd4);
    check("t2_no_req_full", {63'd0, mem_readEn}, 64'd0);
    k_ready = 1'b1;
    cycle();
    k_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      found = (req_cnt - base) == 5;
    end
    check("t2_refill_req", {63'd0, found}, 64'd1);
    check("t2_refill_addr", {32'd0, last_req}, 64'h110);

    // 3: branch while 0x108 is in flight; its data must be swallowed
    k_ready = 1'b1; lat = 3;
    br_on_req = 1'b1; br_addr = 32'h108; br_pc = 32'h200;
    k_start = 1'b1; k_pc = 32'h100;
    cycle();
    base = req_cnt;
    vcnt = 0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      cycle();
      if (!br_on_req && curPipReadyToSend) vcnt++;
      found = (last_req == 32'h200) && (req_cnt > base);
    end
    check("t3_redirect_req", {63'd0, found}, 64'd1);
    check("t3_req_count", (req_cnt - base), 64'd4);
    check("t3_empty_between", vcnt, 64'd0);

    // 4: interrupt coincides with readFin and a would-be pop
    k_ready = 1'b0; lat = 2;
    k_start = 1'b1; k_pc = 32'h300;
    cycle();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle();
      found = sb.size() >= 2;
    end
    check("t4_prefill", {63'd0, found}, 64'd1);
    irq_on_fin = 1'b1; irq_pc = 32'h400;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      found = fired;
    end
    check("t4_irq_fin", {63'd0, found}, 64'd1);
    check("t4_valid_forced", {63'd0, curPipReadyToSend}, 64'd0);
    base = req_cnt;
    cycle();
    check("t4_req_addr", {32'd0, mem_read_addr}, 64'h400);
    check("t4_req_en", {63'd0, mem_readEn}, 64'd1);
    check("t4_req_new", (req_cnt - base), 64'd1);

    // 5: PC wraps past 2^32; upstream permit low stops further reads
    saw_zero = 1'b0;
    k_start = 1'b1; k_pc = 32'hFFFF_FFF8;
    cycle();
    base = req_cnt;
    repeat (40) cycle();
    check("t5_reads", (req_cnt - base), 64'd4);
    check("t5_saw_zero", {63'd0, saw_zero}, 64'd1);
    check("t5_last_addr", {32'd0, last_req}, 64'h4);
    k_before = 1'b0; k_ready = 1'b1;
    cycle();
    k_ready = 1'b0;
    cycle();
    check("t5_wrap_cur", {32'd0, fetch_cur_pc}, 64'hFFFF_FFFC);
    check("t5_wrap_nxt", {32'd0, fetch_nxt_pc}, 64'h0);
    base2 = req_cnt;
    k_ready = 1'b1;
    repeat (8) cycle();
    check("t5_no_new_req", (req_cnt - base2), 64'd0);
    check("t5_readEn_low", {63'd0, mem_readEn}, 64'd0);
    check("t5_drained", {63'd0, curPipReadyToSend}, 64'd0);

    // 6: reset mid-read, completion arrives the cycle after
    k_ready = 1'b0; k_before = 1'b1; lat = 6;
    k_start = 1'b1; k_pc = 32'h500;
    cycle();
    base = req_cnt;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      found = req_cnt > base;
    end
    check("t6_req_seen", {63'd0, found}, 64'd1);
    cycle();
    k_rst = 1'b1;
    cycle();
    k_rst = 1'b0;
    cycle();
    check("t6_fin_after_rst", {63'd0, fired}, 64'd1);
    check_reset_view("t6");
    repeat (3) cycle();
    check_reset_view("t6_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
